// File: rtl/mode_pkg.sv
// Shared types and helpers for the mode sequencer: per-cycle command encoding and
// the encoded-width rule used for both the mode and the timer.
package mode_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD,
        CMD_ADV,
        CMD_RET,
        CMD_TIMEOUT
    } mode_cmd_t;

    // Width needed to encode n distinct values, never less than one bit.
    function automatic int mode_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a level input. The history register resets to RESET_VAL,
// so a level already high at reset release is not seen as an edge.
module edge_rise #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_reg;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            d_reg <= RESET_VAL;
        end else begin
            d_reg <= d;
        end
    end

    assign rise = d & ~d_reg;

endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer: P edges step through NUM_MODES modes, R edges or an inactivity
// timeout return to mode 0. Every output is a register, none are decoded from M.
module mode_sequencer
    import mode_pkg::*;
#(
    parameter int NUM_MODES      = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WRAP           = 1,
    localparam int MW            = mode_width(NUM_MODES)
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 P,
    input  logic                 R,
    input  logic                 lock,
    output logic [MW-1:0]        M,
    output logic [NUM_MODES-1:0] M_onehot,
    output logic                 active,
    output logic                 changed,
    output logic                 timeout
);

    localparam int TW = mode_width(TIMEOUT_CYCLES + 1);
    localparam logic [MW-1:0] LAST_MODE  = MW'(NUM_MODES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic                 p_edge;
    logic                 r_edge;
    logic                 expire;
    mode_cmd_t            cmd;
    logic [MW-1:0]        mode_reg,    mode_next;
    logic [TW-1:0]        timer_reg,   timer_next;
    logic [NUM_MODES-1:0] onehot_reg,  onehot_next;
    logic                 active_reg;
    logic                 changed_reg;
    logic                 timeout_reg;

    edge_rise #(.RESET_VAL(1'b1)) u_p_rise (.CLK(CLK), .reset(reset), .d(P), .rise(p_edge));
    edge_rise #(.RESET_VAL(1'b1)) u_r_rise (.CLK(CLK), .reset(reset), .d(R), .rise(r_edge));

    assign expire = (TIMEOUT_CYCLES != 0) && (mode_reg != '0) && (timer_reg == TIMER_LAST);

    // Lock maps to HOLD here; the next-state logic additionally freezes the timer.
    always_comb begin
        cmd = CMD_HOLD;
        if (!lock) begin
            if (r_edge)      cmd = CMD_RET;
            else if (p_edge) cmd = CMD_ADV;
            else if (expire) cmd = CMD_TIMEOUT;
        end
    end

    always_comb begin
        mode_next  = mode_reg;
        timer_next = timer_reg;
        if (!lock) begin
            case (cmd)
                CMD_ADV: begin
                    if (mode_reg != LAST_MODE) mode_next = mode_reg + MW'(1);
                    else if (WRAP != 0)        mode_next = '0;
                    timer_next = '0;
                end
                CMD_RET, CMD_TIMEOUT: begin
                    mode_next  = '0;
                    timer_next = '0;
                end
                default: begin
                    timer_next = (mode_reg != '0) ? timer_reg + TW'(1) : '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_MODES; gi++) begin : g_onehot
        assign onehot_next[gi] = (mode_next == MW'(gi));
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mode_reg    <= '0;
            timer_reg   <= '0;
            onehot_reg  <= NUM_MODES'(1);
            active_reg  <= 1'b0;
            changed_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            mode_reg    <= mode_next;
            timer_reg   <= timer_next;
            onehot_reg  <= onehot_next;
            active_reg  <= (mode_next != '0);
            changed_reg <= (mode_next != mode_reg);
            timeout_reg <= (cmd == CMD_TIMEOUT);
        end
    end

    assign M        = mode_reg;
    assign M_onehot = onehot_reg;
    assign active   = active_reg;
    assign changed  = changed_reg;
    assign timeout  = timeout_reg;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: default, WRAP=0 and NUM_MODES=5 instances, each cycle's
// expected outputs queued when the stimulus is driven and compared after the edge.
module tb_mode_sequencer;

    logic CLK;
    logic reset;
    logic P_a, R_a, lock_a;
    logic P_w, R_w, lock_w;
    logic P_f, R_f, lock_f;

    logic [1:0] M_a; logic [3:0] M_onehot_a; logic active_a, changed_a, timeout_a;
    logic [1:0] M_w; logic [3:0] M_onehot_w; logic active_w, changed_w, timeout_w;
    logic [2:0] M_f; logic [4:0] M_onehot_f; logic active_f, changed_f, timeout_f;

    typedef struct {
        int m;
        bit ch;
        bit to;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    mode_sequencer u_dflt (
        .CLK(CLK), .reset(reset), .P(P_a), .R(R_a), .lock(lock_a),
        .M(M_a), .M_onehot(M_onehot_a), .active(active_a), .changed(changed_a), .timeout(timeout_a)
    );

    mode_sequencer #(.WRAP(0)) u_nowrap (
        .CLK(CLK), .reset(reset), .P(P_w), .R(R_w), .lock(lock_w),
        .M(M_w), .M_onehot(M_onehot_w), .active(active_w), .changed(changed_w), .timeout(timeout_w)
    );

    mode_sequencer #(.NUM_MODES(5)) u_five (
        .CLK(CLK), .reset(reset), .P(P_f), .R(R_f), .lock(lock_f),
        .M(M_f), .M_onehot(M_onehot_f), .active(active_f), .changed(changed_f), .timeout(timeout_f)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle on instance sel (0 default, 1 no-wrap, 2 five-mode).
    task automatic cyc(input int sel, input logic p, input logic r, input logic lk,
                       input int em, input bit ec, input bit et);
        exp_t e;
        int   om, oh, oa, oc, ot;
        P_a = (sel == 0) ? p : 1'b0; R_a = (sel == 0) ? r : 1'b0; lock_a = (sel == 0) ? lk : 1'b0;
        P_w = (sel == 1) ? p : 1'b0; R_w = (sel == 1) ? r : 1'b0; lock_w = (sel == 1) ? lk : 1'b0;
        P_f = (sel == 2) ? p : 1'b0; R_f = (sel == 2) ? r : 1'b0; lock_f = (sel == 2) ? lk : 1'b0;
        sb_q.push_back('{em, ec, et});
        @(posedge CLK);
        #1;
        e = sb_q.pop_front();
        case (sel)
            1:       begin om = M_w; oh = M_onehot_w; oa = active_w; oc = changed_w; ot = timeout_w; end
            2:       begin om = M_f; oh = M_onehot_f; oa = active_f; oc = changed_f; ot = timeout_f; end
            default: begin om = M_a; oh = M_onehot_a; oa = active_a; oc = changed_a; ot = timeout_a; end
        endcase
        $display("cyc sel=%0d P=%0b R=%0b lock=%0b -> M=%0d onehot=%b chg=%0b to=%0b",
                 sel, p, r, lk, om, oh[4:0], oc[0], ot[0]);
        chk("M", om, e.m);
        chk("M_onehot", oh, 1 << e.m);
        chk("active", oa, (e.m != 0) ? 1 : 0);
        chk("changed", oc, int'(e.ch));
        chk("timeout", ot, int'(e.to));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        P_a = 1'b1; R_a = 1'b0; lock_a = 1'b0;
        P_w = 1'b0; R_w = 1'b0; lock_w = 1'b0;
        P_f = 1'b0; R_f = 1'b0; lock_f = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_M", M_a, 0);
        chk("rst_onehot", M_onehot_a, 1);
        chk("rst_active", active_a, 0);
        chk("rst_changed", changed_a, 0);
        chk("rst_timeout", timeout_a, 0);
        reset = 1'b0;

        // P held high across reset release is not an edge
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 1, 0, 0, k, 1, 0);
            cyc(0, 0, 0, 0, k, 0, 0);
        end
        // wrap from last mode
        cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // timeout: mode 1 visible for exactly 16 cycles
        cyc(0, 1, 0, 0, 1, 1, 0);
        for (int k = 0; k < 15; k++) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // P at cycle 10 restarts the count
        cyc(0, 1, 0, 0, 1, 1, 0);
        for (int k = 0; k < 9; k++) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 2, 1, 0);
        for (int k = 0; k < 15; k++) cyc(0, 0, 0, 0, 2, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // simultaneous P and R from mode 2, then R in mode 0
        cyc(0, 1, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 2, 1, 0);
        cyc(0, 0, 0, 0, 2, 0, 0);
        cyc(0, 1, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // lock for 20 cycles with P pulses inside
        cyc(0, 1, 0, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) cyc(0, (i % 4 == 1), 0, 1, 1, 0, 0);
        for (int k = 0; k < 15; k++) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // async reset mid-cycle at mode 3, timer 9
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 1, 0, 0, k, 1, 0);
            if (k < 3) cyc(0, 0, 0, 0, k, 0, 0);
        end
        for (int k = 0; k < 9; k++) cyc(0, 0, 0, 0, 3, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_M", M_a, 0);
        chk("async_onehot", M_onehot_a, 1);
        chk("async_active", active_a, 0);
        chk("async_changed", changed_a, 0);
        #2;
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0);

        // WRAP=0 saturates at mode 3
        for (int k = 1; k <= 3; k++) begin
            cyc(1, 1, 0, 0, k, 1, 0);
            cyc(1, 0, 0, 0, k, 0, 0);
        end
        cyc(1, 1, 0, 0, 3, 0, 0);
        cyc(1, 0, 0, 0, 3, 0, 0);

        // NUM_MODES=5 walks 0..4 then wraps
        for (int k = 1; k <= 4; k++) begin
            cyc(2, 1, 0, 0, k, 1, 0);
            cyc(2, 0, 0, 0, k, 0, 0);
        end
        cyc(2, 1, 0, 0, 0, 1, 0);
        cyc(2, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
- Parametrised successor to the single-bit P/R mode latch.
- Steps through NUM_MODES operating modes: P advances, R returns to mode 0, and an inactivity timeout also returns to mode 0.
- P and R are level inputs (buttons or upstream strobes) and are edge-detected internally.
- Sits between user/control inputs and the datapath mode selects, and drives both an encoded and a one-hot mode output.

Parameters:
- NUM_MODES, 4: number of modes, must be >= 2. Mode 0 is the idle/default mode.
- TIMEOUT_CYCLES, 16: cycles spent in any nonzero mode without a P edge before an automatic return to mode 0. Value 0 disables the timeout.
- WRAP, 1: 1 means P in the last mode wraps to mode 0. 0 means P saturates at mode NUM_MODES-1.
- MW, derived: max(1, $clog2(NUM_MODES)), the encoded mode width. It is not overridable.

Ports:
- CLK  in  1  system clock; rising edge active
- reset  in  1  asynchronous, active-high reset
- P  in  1  advance request (level), acted on at its rising edge
- R  in  1  return-to-idle request (level), acted on at its rising edge
- lock  in  1  freeze: while high, mode, timer and pulses are held
- M  out  MW  current mode, encoded
- M_onehot  out  NUM_MODES  current mode, one-hot; bit i high iff M==i
- active  out  1  high iff M != 0
- changed  out  1  one-cycle pulse in the first cycle a new M is visible
- timeout  out  1  one-cycle pulse in the first cycle after a timeout return

Behaviour:
- Clock and reset: single clock CLK. Reset is asynchronous and active-high, named reset; it overrides everything including lock.
- Reset values:
  - M=0, M_onehot=1, active=0, changed=0, timeout=0, timer=0.
  - The P and R history registers reset to 1. A request held high across reset release does not count as an edge.
- Edge detection:
  - p_edge = P & ~p_q and r_edge = R & ~r_q, both evaluated at each CLK edge.
  - p_q and r_q update every cycle, including while lock is high. Edges that occur during lock are discarded, not queued.
- Command priority per cycle (highest first): lock, then r_edge, then p_edge, then timer expiry, then hold.
  - lock=1: M, timer and the other state are held. changed=0, timeout=0.
  - r_edge: M becomes 0. changed=1 only if M was nonzero. timer cleared. A simultaneous p_edge is ignored.
  - p_edge:
    - If M < NUM_MODES-1, M becomes M+1.
    - Else, if WRAP=1, M becomes 0.
    - Else (WRAP=0), M is held and changed stays 0.
    - timer is cleared in all three cases.
  - Expiry: when TIMEOUT_CYCLES != 0, M != 0 and timer == TIMEOUT_CYCLES-1:
    - M becomes 0, timeout=1, changed=1, timer cleared.
  - Otherwise: if M != 0, timer increments; if M == 0, timer stays 0.
- Latency:
  - A P rise set up before edge k updates M after edge k, and changed is high during cycle k to k+1. There is no added pipeline stage.
  - A mode entered at edge k, with no further edges and no lock, returns to 0 at edge k+TIMEOUT_CYCLES. The nonzero mode therefore lasts exactly TIMEOUT_CYCLES cycles.
- Outputs: all are registered and glitch-free. M_onehot and active are registered alongside M, not decoded combinationally from it.
- Widths:
  - timer width is max(1, $clog2(TIMEOUT_CYCLES+1)).
  - The increment from NUM_MODES-1 must never produce an out-of-range encoding, including non-power-of-2 NUM_MODES (e.g. 5 or 3).
- Reset mid-operation: M returns to 0 immediately and asynchronously. All pulses drop, and the timer clears.

Decomposition:
- Package mode_pkg:
  - typedef enum mode_cmd_t {CMD_HOLD, CMD_ADV, CMD_RET, CMD_TIMEOUT}.
  - Function mode_width(n) returning max(1, $clog2(n)).
- Sub-module edge_rise:
  - Parameter RESET_VAL; ports CLK, reset, d, rise.
  - Instantiated once for P and once for R.
- Top level contains:
  - a command priority encoder producing mode_cmd_t;
  - the mode register;
  - the timer;
  - the output registers.

Test Plan:
Defaults NUM_MODES=4, TIMEOUT_CYCLES=16, WRAP=1 unless stated.
- Reset with P held high, then release: M stays 0 with no changed pulse. Drop P, then pulse P high for 1 cycle three times: M=1,2,3, M_onehot=0010,0100,1000, and changed pulses 3 times.
- From M=3, pulse P: M=0, active=0, changed=1. Repeat with WRAP=0: M stays 3, changed=0.
- Pulse P once, then idle: M=1 for exactly 16 cycles, then M=0 with timeout=1 and changed=1 for one cycle. A P pulse at cycle 10 gives M=2 and restarts the 16-cycle count.
- P and R rise in the same cycle from M=2: M=0 with changed=1. R rise while M=0: changed stays 0.
- From M=1, raise lock for 20 cycles with P pulses inside: M stays 1 with no timeout. After lock falls, 16 more cycles pass before the timeout.
- Assert reset asynchronously mid-cycle at M=3 with the timer at 9: M=0 and M_onehot=0001 before the next CLK edge. Repeat with NUM_MODES=5: M walks 0..4 and never reaches 5–7.
